// File: rtl/arc4_encrypt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arc4_encrypt : ARC4 encryptor, length-prefixed pt[] -> ct[] using shared S.
// Rev 1.0      : optional ARC4_ENC_ZEROFILL_EN zero-fills ct[len+1..255].
// ----------------------------------------------------------------------------
module arc4_encrypt #(
  parameter int MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RDLEN = 4'd1,
    WTLEN = 4'd2,
    WRLEN = 4'd3,
    RDI   = 4'd4,
    WTI   = 4'd5,
    RDJ   = 4'd6,
    WTJ   = 4'd7,
    WRI   = 4'd8,
    WRJ   = 4'd9,
    RDPAD = 4'd10,
    WTPAD = 4'd11,
    WRCT  = 4'd12,
    FILL  = 4'd13
  } state_t;

  state_t     state_q;
  logic [7:0] i_q, j_q, k_q, len_q, si_q, sj_q;
  logic       rdy_q, s_wren_q, ct_wren_q;
  logic [7:0] s_addr_q, s_wrdata_q, pt_addr_q, ct_addr_q, ct_wrdata_q;

  logic [7:0] len_d, i_d, j_d, pad_addr_d;

  always_comb begin
    len_d      = (pt_rddata > MAX_LEN_B) ? MAX_LEN_B : pt_rddata;
    i_d        = i_q + 8'd1;
    j_d        = j_q + s_rddata;
    pad_addr_d = si_q + sj_q;
  end

  // Every output is registered: each transition loads what the next state drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      len_q       <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      s_wren_q    <= 1'b0;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      ct_wren_q   <= 1'b0;
    end else begin
      s_wren_q  <= 1'b0;
      ct_wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q   <= RDLEN;
            rdy_q     <= 1'b0;
            pt_addr_q <= 8'd0;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= 8'd0;
          end
        end
        RDLEN: state_q <= WTLEN;
        WTLEN: begin
          len_q       <= len_d;
          ct_addr_q   <= 8'd0;
          ct_wrdata_q <= len_d;
          ct_wren_q   <= 1'b1;
          state_q     <= WRLEN;
        end
        WRLEN: begin
          if (len_q == 8'd0) begin
`ifdef ARC4_ENC_ZEROFILL_EN
            state_q     <= FILL;
            ct_addr_q   <= 8'd1;
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b1;
`else
            state_q <= IDLE;
            rdy_q   <= 1'b1;
`endif
          end else begin
            i_q      <= i_d;
            s_addr_q <= i_d;
            k_q      <= 8'd1;
            state_q  <= RDI;
          end
        end
        RDI: state_q <= WTI;
        WTI: begin
          si_q     <= s_rddata;
          j_q      <= j_d;
          s_addr_q <= j_d;
          state_q  <= RDJ;
        end
        RDJ: state_q <= WTJ;
        WTJ: begin
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= WRI;
        end
        WRI: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          state_q    <= WRJ;
        end
        WRJ: begin
          s_addr_q  <= pad_addr_d;
          pt_addr_q <= k_q;
          state_q   <= RDPAD;
        end
        RDPAD: state_q <= WTPAD;
        WTPAD: begin
          ct_addr_q   <= k_q;
          ct_wrdata_q <= pt_rddata ^ s_rddata;
          ct_wren_q   <= 1'b1;
          state_q     <= WRCT;
        end
        WRCT: begin
          if (k_q == len_q) begin
`ifdef ARC4_ENC_ZEROFILL_EN
            if (len_q == 8'hFF) begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
            end else begin
              state_q     <= FILL;
              ct_addr_q   <= len_q + 8'd1;
              ct_wrdata_q <= 8'd0;
              ct_wren_q   <= 1'b1;
            end
`else
            state_q <= IDLE;
            rdy_q   <= 1'b1;
`endif
          end else begin
            k_q      <= k_q + 8'd1;
            i_q      <= i_d;
            s_addr_q <= i_d;
            state_q  <= RDI;
          end
        end
`ifdef ARC4_ENC_ZEROFILL_EN
        FILL: begin
          if (ct_addr_q == 8'hFF) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end else begin
            ct_addr_q <= ct_addr_q + 8'd1;
            ct_wren_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign pt_addr   = pt_addr_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign ct_wren   = ct_wren_q;

endmodule
`default_nettype wire
